// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
//   Programmable-mode VGA timing generator. It also produces scaled
//   framebuffer read coordinates and a fixed-latency alignment pipeline.
//   Sync, blanking and the line/frame strobes are delayed so that they
//   appear in the same cycle as the colour fetched for the same counter
//   state. Every output lags the raw counters by FETCH_LATENCY+2 clocks.
//
// Ports
//   clk_25_175      in   pixel clock
//   reset           in   asynchronous reset, active-low
//   pixstream       in   fetched pixel {b, g, r}, valid FETCH_LATENCY clocks
//                        after its coordinate is presented
//   hreadwire       out  scaled horizontal framebuffer coordinate
//   vreadwire       out  scaled vertical framebuffer coordinate
//   h_sync, v_sync  out  sync pulses, pipeline-aligned, polarity by parameter
//   drawing_pixels  out  active-video flag, pipeline-aligned
//   line_start      out  pulse on first active pixel of each active line
//   frame_start     out  pulse on pixel (0,0)
//   r, g, b         out  colour, zero outside active video
// ---------------------------------------------------------------------------
module vga_timing_pipe #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int HSYNC_POL     = 0,
  parameter int VSYNC_POL     = 0,
  parameter int COLOR_BITS    = 4,
  parameter int PIX_REP       = 1,
  parameter int FETCH_LATENCY = 1,
  parameter int COORD_W       = 11
) (
  input  logic                      clk_25_175,
  input  logic                      reset,
  input  logic [3*COLOR_BITS-1:0]   pixstream,
  output logic [COORD_W-1:0]        hreadwire,
  output logic [COORD_W-1:0]        vreadwire,
  output logic                      h_sync,
  output logic                      v_sync,
  output logic                      drawing_pixels,
  output logic                      line_start,
  output logic                      frame_start,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // one stage for the decode register, FETCH_LATENCY+1 for alignment
  localparam int STAGES  = FETCH_LATENCY + 2;
  localparam int CW1     = COORD_W + 1;

  generate
    if (PIX_REP < 1 || PIX_REP > 16 || FETCH_LATENCY < 0 || FETCH_LATENCY > 7 ||
        COLOR_BITS < 1 || COLOR_BITS > 8 ||
        $clog2(H_TOTAL) > COORD_W || $clog2(V_TOTAL) > COORD_W) begin : g_bad_params
      $error("vga_timing_pipe: illegal parameter set");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [3:0]         REP_LAST = 4'(PIX_REP - 1);

  // window bounds carry one extra bit so an end bound equal to the total
  // cannot alias back to zero
  localparam logic [COORD_W:0] H_ACT_X  = CW1'(H_ACTIVE);
  localparam logic [COORD_W:0] V_ACT_X  = CW1'(V_ACTIVE);
  localparam logic [COORD_W:0] HS_BEG_X = CW1'(H_ACTIVE + H_FP);
  localparam logic [COORD_W:0] HS_END_X = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W:0] VS_BEG_X = CW1'(V_ACTIVE + V_FP);
  localparam logic [COORD_W:0] VS_END_X = CW1'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  logic [COORD_W-1:0] hcnt, vcnt;
  logic [COORD_W-1:0] hx, vy;
  logic [3:0]         hsub, vsub;
  logic               h_wrap, v_wrap;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // raw scan counters; hx/vy track hcnt/PIX_REP and vcnt/PIX_REP without a divider
  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
      hsub <= '0;
      vsub <= '0;
      hx   <= '0;
      vy   <= '0;
    end else begin
      if (h_wrap) begin
        hcnt <= '0;
        hsub <= '0;
        hx   <= '0;
        if (v_wrap) begin
          vcnt <= '0;
          vsub <= '0;
          vy   <= '0;
        end else begin
          vcnt <= vcnt + COORD_W'(1);
          if (vsub == REP_LAST) begin
            vsub <= '0;
            vy   <= vy + COORD_W'(1);
          end else begin
            vsub <= vsub + 4'd1;
          end
        end
      end else begin
        hcnt <= hcnt + COORD_W'(1);
        if (hsub == REP_LAST) begin
          hsub <= '0;
          hx   <= hx + COORD_W'(1);
        end else begin
          hsub <= hsub + 4'd1;
        end
      end
    end
  end

  logic [COORD_W:0] hcnt_x, vcnt_x;
  logic             h_win, v_win, active, first_px, first_frame_px;

  always_comb begin
    hcnt_x         = {1'b0, hcnt};
    vcnt_x         = {1'b0, vcnt};
    h_win          = (hcnt_x >= HS_BEG_X) && (hcnt_x < HS_END_X);
    v_win          = (vcnt_x >= VS_BEG_X) && (vcnt_x < VS_END_X);
    active         = (hcnt_x < H_ACT_X) && (vcnt_x < V_ACT_X);
    first_px       = active && (hcnt == '0);
    first_frame_px = first_px && (vcnt == '0);
  end

  // pipe entries hold {h_win, v_win, active, line_start, frame_start};
  // sync is kept as an in-window flag so a cleared stage means idle level
  logic [4:0]                pipe [STAGES];
  logic [3*COLOR_BITS-1:0]   pix_q;

  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      hreadwire <= '0;
      vreadwire <= '0;
      pix_q     <= '0;
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      hreadwire <= hx;
      vreadwire <= vy;
      pix_q     <= pixstream;
      pipe[0]   <= {h_win, v_win, active, first_px, first_frame_px};
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic [4:0] tail;
  assign tail = pipe[STAGES-1];

  assign h_sync         = tail[4] ? HS_ON : ~HS_ON;
  assign v_sync         = tail[3] ? VS_ON : ~VS_ON;
  assign drawing_pixels = tail[2];
  assign line_start     = tail[1];
  assign frame_start    = tail[0];

  assign r = pix_q[COLOR_BITS-1:0]              & {COLOR_BITS{tail[2]}};
  assign g = pix_q[2*COLOR_BITS-1:COLOR_BITS]   & {COLOR_BITS{tail[2]}};
  assign b = pix_q[3*COLOR_BITS-1:2*COLOR_BITS] & {COLOR_BITS{tail[2]}};

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Four DUT instances share clock and reset:
//   0: small mode 8/2/3/2 x 4/1/2/1, FETCH_LATENCY 1, PIX_REP 1, coordinate pattern
//   1: 9/2/3/2 x 6/1/2/1, FETCH_LATENCY 3, PIX_REP 3, sync active-high, random ROM
//   2: small mode, FETCH_LATENCY 0, random ROM
//   3: small mode, FETCH_LATENCY 7, random ROM
module tb_vga_timing_pipe;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, rep, fl, hpol, vpol, sel;
  } mode_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] pix [4];
  logic [10:0] hr [4];
  logic [10:0] vr [4];
  logic        hs [4];
  logic        vs [4];
  logic        de [4];
  logic        ls [4];
  logic        fs [4];
  logic [3:0]  rr [4];
  logic [3:0]  gg [4];
  logic [3:0]  bb [4];

  vga_timing_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0),
    .COLOR_BITS(4), .PIX_REP(1), .FETCH_LATENCY(1), .COORD_W(11)) u_dut0 (
    .clk_25_175(clk), .reset(rst_n), .pixstream(pix[0]), .hreadwire(hr[0]),
    .vreadwire(vr[0]), .h_sync(hs[0]), .v_sync(vs[0]), .drawing_pixels(de[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .r(rr[0]), .g(gg[0]), .b(bb[0]));

  vga_timing_pipe #(.H_ACTIVE(9), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1), .VSYNC_POL(1),
    .COLOR_BITS(4), .PIX_REP(3), .FETCH_LATENCY(3), .COORD_W(11)) u_dut1 (
    .clk_25_175(clk), .reset(rst_n), .pixstream(pix[1]), .hreadwire(hr[1]),
    .vreadwire(vr[1]), .h_sync(hs[1]), .v_sync(vs[1]), .drawing_pixels(de[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .r(rr[1]), .g(gg[1]), .b(bb[1]));

  vga_timing_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0),
    .COLOR_BITS(4), .PIX_REP(1), .FETCH_LATENCY(0), .COORD_W(11)) u_dut2 (
    .clk_25_175(clk), .reset(rst_n), .pixstream(pix[2]), .hreadwire(hr[2]),
    .vreadwire(vr[2]), .h_sync(hs[2]), .v_sync(vs[2]), .drawing_pixels(de[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .r(rr[2]), .g(gg[2]), .b(bb[2]));

  vga_timing_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(0), .VSYNC_POL(0),
    .COLOR_BITS(4), .PIX_REP(1), .FETCH_LATENCY(7), .COORD_W(11)) u_dut3 (
    .clk_25_175(clk), .reset(rst_n), .pixstream(pix[3]), .hreadwire(hr[3]),
    .vreadwire(vr[3]), .h_sync(hs[3]), .v_sync(vs[3]), .drawing_pixels(de[3]),
    .line_start(ls[3]), .frame_start(fs[3]), .r(rr[3]), .g(gg[3]), .b(bb[3]));

  // framebuffer model: combinational lookup followed by a read-latency delay
  logic [11:0] rom [256];
  logic [11:0] src [4];
  logic [11:0] dl  [4][8];

  always_comb begin
    src[0] = {hr[0][3:0], vr[0][3:0], 4'hA};
    for (int i = 1; i < 4; i++) src[i] = rom[{vr[i][3:0], hr[i][3:0]}];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 7; j > 0; j--) dl[i][j] <= dl[i][j-1];
      dl[i][0] <= src[i];
    end
  end

  assign pix[0] = dl[0][0];
  assign pix[1] = dl[1][2];
  assign pix[2] = src[2];
  assign pix[3] = dl[3][6];

  mode_t md [4];
  int    checks = 0;
  int    errors = 0;
  int    k = 0;
  int    hs_low = 0, vs_low = 0, de_cnt = 0, ls_cnt = 0, fs_cnt = 0, hs_low_line = 0;

  function automatic logic [63:0] pack(input logic h, input logic v, input logic d,
                                       input logic l, input logic f, input logic [3:0] cr,
                                       input logic [3:0] cg, input logic [3:0] cb,
                                       input logic [10:0] x, input logic [10:0] y);
    return {25'b0, h, v, d, l, f, cr, cg, cb, x, y};
  endfunction

  function automatic logic [11:0] pixel(input int sel, input int x, input int y);
    logic [3:0] xs, ys;
    xs = 4'(x % 16);
    ys = 4'(y % 16);
    if (sel == 0) return {xs, ys, 4'hA};
    return rom[{ys, xs}];
  endfunction

  // expected outputs after k clock edges since reset release; the counters
  // reach state index n after n edges, coordinates lag by one clock and
  // everything else by fl+2 clocks
  function automatic logic [63:0] model(input mode_t m, input int kk);
    int ht, vt, st, h, v;
    logic xh, xv, xd, xl, xf;
    logic [11:0] px;
    logic [10:0] cx, cy;
    ht = m.ha + m.hf + m.hsw + m.hb;
    vt = m.va + m.vf + m.vsw + m.vb;
    xh = (m.hpol == 0);
    xv = (m.vpol == 0);
    xd = 1'b0; xl = 1'b0; xf = 1'b0;
    px = '0; cx = '0; cy = '0;
    if (kk >= 1) begin
      st = kk - 1;
      cx = 11'((st % ht) / m.rep);
      cy = 11'(((st / ht) % vt) / m.rep);
    end
    st = kk - (m.fl + 2);
    if (st >= 0) begin
      h  = st % ht;
      v  = (st / ht) % vt;
      xd = (h < m.ha) && (v < m.va);
      xl = xd && (h == 0);
      xf = xd && (h == 0) && (v == 0);
      if (h >= m.ha + m.hf && h < m.ha + m.hf + m.hsw) xh = (m.hpol != 0);
      if (v >= m.va + m.vf && v < m.va + m.vf + m.vsw) xv = (m.vpol != 0);
      if (xd) px = pixel(m.sel, h / m.rep, v / m.rep);
    end
    return pack(xh, xv, xd, xl, xf, px[3:0], px[7:4], px[11:8], cx, cy);
  endfunction

  function automatic logic [63:0] observed(input int i);
    return pack(hs[i], vs[i], de[i], ls[i], fs[i], rr[i], gg[i], bb[i], hr[i], vr[i]);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp,
                       input int at);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, at, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_dut%0d", tag, i), observed(i), model(md[i], k), k);
  endtask

  task automatic run(input int ncyc, input bit count_win);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all("scan");
      if (count_win && k >= 10 && k < 130) begin
        if (!hs[0]) hs_low++;
        if (!vs[0]) vs_low++;
        if (de[0])  de_cnt++;
        if (ls[0])  ls_cnt++;
        if (fs[0])  fs_cnt++;
        if (k < 25 && !hs[0]) hs_low_line++;
      end
    end
  endtask

  initial begin
    md[0] = '{ha:8, hf:2, hsw:3, hb:2, va:4, vf:1, vsw:2, vb:1, rep:1, fl:1, hpol:0, vpol:0, sel:0};
    md[1] = '{ha:9, hf:2, hsw:3, hb:2, va:6, vf:1, vsw:2, vb:1, rep:3, fl:3, hpol:1, vpol:1, sel:1};
    md[2] = '{ha:8, hf:2, hsw:3, hb:2, va:4, vf:1, vsw:2, vb:1, rep:1, fl:0, hpol:0, vpol:0, sel:1};
    md[3] = '{ha:8, hf:2, hsw:3, hb:2, va:4, vf:1, vsw:2, vb:1, rep:1, fl:7, hpol:0, vpol:0, sel:1};
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);

    // held in reset: idle levels everywhere
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    k = 0;
    check_all("in_reset");

    // run to hcnt=5, vcnt=2 of the small mode, then reset between edges
    rst_n = 1'b1;
    run(35, 1'b0);
    #2 rst_n = 1'b0;
    #1 k = 0;
    check_all("async_rst_mid_line");

    repeat ($urandom_range(4, 1)) @(negedge clk);
    rst_n = 1'b1;
    run($urandom_range(250, 150), 1'b0);
    #2 rst_n = 1'b0;
    #1 k = 0;
    check_all("async_rst_random");

    repeat ($urandom_range(4, 1)) @(negedge clk);
    rst_n = 1'b1;
    run(300, 1'b1);

    // one full 120-clock frame of the small mode, pipeline already filled
    check("hsync_low_per_line",  64'(hs_low_line), 64'(3),  -1);
    check("hsync_low_per_frame", 64'(hs_low),      64'(24), -1);
    check("vsync_low_per_frame", 64'(vs_low),      64'(30), -1);
    check("active_per_frame",    64'(de_cnt),      64'(32), -1);
    check("line_start_count",    64'(ls_cnt),      64'(4),  -1);
    check("frame_start_count",   64'(fs_cnt),      64'(1),  -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
Parametrised successor of the team's VGA scan core. It generates programmable-mode VGA timing with selectable sync polarity and a pixel-replication (scale-down) factor for framebuffer coordinates. A fixed-latency fetch pipeline delays sync, blanking and colour so they stay aligned with pixel data from a framebuffer/ROM of known read latency. It sits between the tetris framebuffer logic (coordinate consumer, pixel producer) and the board's VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, h_sync level during the pulse (0 = active-low)
VSYNC_POL, 0, v_sync level during the pulse
COLOR_BITS, 4, bits per colour channel (1..8)
PIX_REP, 1, pixel replication factor, applied to both axes (1..16)
FETCH_LATENCY, 1, clocks from coordinate change to valid pixstream (0..7)
COORD_W, 11, coordinate/counter width (≥ clog2 of H and V totals)

Ports:
clk_25_175  in  1  pixel clock
reset  in  1  asynchronous, active-low
pixstream  in  3*COLOR_BITS  pixel for the presented coordinate: [CB-1:0]=r, [2CB-1:CB]=g, [3CB-1:2CB]=b
hreadwire  out  COORD_W  scaled horizontal framebuffer coordinate
vreadwire  out  COORD_W  scaled vertical framebuffer coordinate
h_sync  out  1  horizontal sync, pipeline-aligned
v_sync  out  1  vertical sync, pipeline-aligned
drawing_pixels  out  1  active-video flag, pipeline-aligned
line_start  out  1  1-clock pulse on first active pixel of each active line (aligned)
frame_start  out  1  1-clock pulse on first active pixel of frame, pixel (0,0) (aligned)
r, g, b  out  COLOR_BITS each  colour, forced to 0 when drawing_pixels=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. hcnt counts 0..H_TOTAL-1 exactly, with no extra clock at wrap. vcnt increments when hcnt wraps and wraps V_TOTAL-1 -> 0.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- Sync pulse windows: hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). In-window level = *_POL; otherwise the inverse.
- Scaling uses sub-counters, with no divider.
  - hsub counts 0..PIX_REP-1; hreadwire increments when hsub wraps. hsub and hreadwire are reset to 0 when hcnt wraps.
  - vsub/vreadwire behave the same per line. Both are reset to 0 at frame wrap.
  - Coordinates keep counting through blanking; consumers ignore them there. H_TOTAL need not be a multiple of PIX_REP.
- hreadwire/vreadwire are registered. They present counter state C in cycle t+1 when hcnt/vcnt hold C in cycle t.
- pixstream is valid FETCH_LATENCY clocks after its coordinate appears and is registered into r/g/b. Colour for C therefore appears at t+2+FETCH_LATENCY.
- Sync, drawing_pixels, line_start and frame_start are computed from C and passed through a (FETCH_LATENCY+1)-stage shift register. They appear in the same cycle as C's colour, so all outputs share one latency: L = FETCH_LATENCY+2 clocks after the counter state.
- r/g/b = registered pixstream AND aligned drawing_pixels.
- Reset (async assert, any cycle, mid-frame included):
  - hcnt, vcnt, subs and read coordinates = 0.
  - Pipeline cleared: h_sync=~HSYNC_POL, v_sync=~VSYNC_POL, drawing_pixels=0, strobes=0, r/g/b=0.
  - After deassertion, counting starts at (0,0) on the first clock edge. frame_start fires exactly L clocks after that edge.
- The first L clocks after reset present the blank/idle values above; there is no garbage.
- Simultaneous h and v wrap: vcnt->0, vsub->0, vreadwire->0 and hcnt->0 in the same edge.
- Illegal parameters (PIX_REP=0, FETCH_LATENCY>7, COORD_W too small) are rejected by an elaboration-time check.

Test Plan:
- Small mode H=8/2/3/2 (H_TOTAL 15), V=4/1/2/1 (V_TOTAL 8), FETCH_LATENCY=1, PIX_REP=1:
  - h_sync low for exactly 3 clocks per 15-clock period and v_sync low for exactly 30 clocks per 120-clock frame.
  - drawing_pixels high for 8 of every 15 clocks on 4 lines.
- Same mode, pixstream driven combinationally from the coordinates as {hreadwire[3:0], vreadwire[3:0], 4'hA} through a FETCH_LATENCY-deep delay:
  - r/g/b at output pixel (x,y) equal (4'hA, y, x).
  - Colour is 0 whenever drawing_pixels=0.
- PIX_REP=3, H_ACTIVE=9:
  - hreadwire sequence in active region 0,0,0,1,1,1,2,2,2, then continues into blanking and returns to 0 at line wrap.
  - vreadwire increments every 3 lines and resets at frame wrap.
- FETCH_LATENCY swept 0, 3, 7:
  - frame_start first asserts 2, 5 and 9 clocks after reset release respectively.
  - Edges of h_sync, drawing_pixels and r/g/b shift by the same amount.
- HSYNC_POL=1, VSYNC_POL=1: syncs idle 0 in reset and outside the pulse window, and pulse high with identical timing.
- Assert reset asynchronously mid-line (hcnt=5, vcnt=2):
  - All outputs go to their idle values without waiting for a clock edge.
  - On release, timing restarts from (0,0); line_start pulses once per active line and frame_start once per frame.
